i2c_reg_slave: RTL and testbench
================================

Name: i2c_reg_slave

Overview:
- Register-mapped I2C responder: 7-bit addressed target with a DEPTH x 8 internal register file, an 8-bit pointer byte and pointer auto-increment.
- Answers the existing i2c_master on the shared open-drain sda/scl bus.
- Exposes committed writes and a local read port to the surrounding system logic.
- No clock stretching; scl is only sampled, never driven.

Parameters:
DEPTH, 16, number of 8-bit registers; power of two, 2..256; PW = log2(DEPTH).

Ports:
clk  input  1  system clock; must be >= 10x SCL rate.
rst  input  1  asynchronous, active-low reset.
own_addr  input  7  target address; sampled on every START.
scl  input  1  I2C clock from the bus (pulled up).
sda  inout  1  open-drain data; driven 0 or high-Z only.
reg_rd_addr  input  PW  local read address.
reg_rd_data  output  8  regs[reg_rd_addr], registered, 1-clk latency.
wr_valid  output  1  one-clk pulse per byte committed by I2C write.
wr_addr  output  PW  register index written; valid with wr_valid.
wr_data  output  8  byte written; valid with wr_valid.
busy  output  1  high from address ACK to STOP/START/NACK release.

Behaviour:
- Reset (rst=0, async): regs, pointer, shift register, bit counter, reg_rd_data, wr_* all 0; busy=0; sda released; state IDLE. A reset mid-transfer releases sda on the same edge.
- Input conditioning: scl/sda pass through 2-FF synchronizers; edges are detected on the synchronized values.
  - START: sda falls while scl high. STOP: sda rises while scl high.
- Bit timing: sda is sampled on the synchronized scl rising edge. Drive changes happen only on the synchronized scl falling edge. Shifts are MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits + R/W). On match, drive ACK next low phase, go to ADDR_ACK. On mismatch, do not drive and go to WAIT_STOP.
  - ADDR_ACK: set busy=1. If R/W=0, go to PTR. If R/W=1, load regs[ptr] into the shift register and go to RDATA.
  - PTR: shift 8 bits; ptr <= byte[PW-1:0] (upper bits ignored, i.e. modulo DEPTH). ACK, then go to WDATA.
  - WDATA: after 8 bits, regs[ptr] <= byte. Pulse wr_valid with wr_addr=ptr and wr_data=byte on the clk of the 8th sample. Then ptr <= ptr+1 (wraps DEPTH-1 to 0), ACK, stay in WDATA.
  - RDATA: drive bit (0 = pull low, 1 = release) for 8 bits, then release sda and sample the master ACK on the 9th scl rise.
    - ACK (0): ptr <= ptr+1 (wrap), load regs[new ptr], continue in RDATA.
    - NACK (1): ptr <= ptr+1, go to WAIT_STOP.
  - WAIT_STOP: sda released; wait for STOP or START.
- STOP in any state: go to IDLE, busy=0, sda released.
- START (including repeated START) in any state: go to ADDR, bit counter cleared, sda released.
- ptr persists across transactions. A read with no preceding pointer write continues from the current ptr.
- A partial byte cut off by START/STOP is discarded: no register write, no wr_valid.
- The ACK bit drive is held through the whole 9th scl high phase and released on the following scl fall.
- reg_rd_data reflects a write one clk after the regs update.
- General call (address 0) is not supported: NACK.

Test Plan:
- own_addr=7'h51. Write 0xA2, 0x03, 0x3C, 0x5A, STOP -> ACK on all 4 bytes. regs[3]=0x3C, regs[4]=0x5A. Two wr_valid pulses: (3,0x3C) then (4,0x5A). busy drops after STOP.
- Write 0xA2, 0x03; repeated START; 0xA3; read 2 bytes, master ACK then NACK -> slave returns 0x3C, 0x5A. sda released after the NACK. ptr=5.
- Send address byte 0xA0 (wrong address) followed by 0x55 -> no ACK on either byte. busy stays 0, no wr_valid, regs unchanged.
- Write 0xA2, 0x0F, 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22 (wrap). Pointer byte 0x13 -> ptr=3.
- Start a read of a byte with MSB 0 (sda held low by the slave); assert rst mid-byte -> sda goes high-Z immediately. All outputs at reset values.
- Write 0xA2, 0x07, then 4 bits of data, then STOP -> regs[7] unchanged, no wr_valid, state IDLE, ptr=7.

Source files
------------

// File: rtl/i2c_reg_slave.sv
// I2C register target: 7-bit address, 8-bit pointer byte with auto-increment,
// DEPTH x 8 register file, local read port and committed-write strobe.
module i2c_reg_slave #(
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [6:0]    own_addr,
  input  logic          scl,
  inout  wire           sda,
  input  logic [PW-1:0] reg_rd_addr,
  output logic [7:0]    reg_rd_data,
  output logic          wr_valid,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  // state      | meaning
  // IDLE       | bus free, waiting for START
  // ADDR       | shifting address + R/W
  // ADDR_ACK   | acknowledging our address
  // PTR        | receiving pointer byte (+ ACK)
  // WDATA      | receiving data bytes (+ ACK)
  // RDATA      | transmitting data, sampling master ACK
  // WAIT_STOP  | not addressed / read done, sda released
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WDATA, RDATA, WAIT_STOP
  } state_t;

  state_t state, state_nxt;

  logic [1:0]    scl_sync, sda_sync;
  logic          scl_q, sda_q;
  logic          scl_s, sda_s;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]    sr;
  logic [7:0]    rx_byte;
  logic [3:0]    bit_cnt;
  logic [PW-1:0] ptr;
  logic [6:0]    own_addr_q;
  logic          sda_oe;
  logic          addr_match;
  logic [7:0]    regs [DEPTH];

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // synchronizers reset to the idle-bus level so reset release creates no edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign scl_s      = scl_sync[1];
  assign sda_s      = sda_sync[1];
  assign scl_rise   = scl_s & ~scl_q;
  assign scl_fall   = ~scl_s & scl_q;
  assign start_det  = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det   = scl_s & scl_q & ~sda_q & sda_s;
  assign rx_byte    = {sr[6:0], sda_s};
  assign addr_match = (rx_byte[7:1] == own_addr_q) && (own_addr_q != 7'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = IDLE;
    end else if (start_det) begin
      state_nxt = ADDR;
    end else begin
      case (state)
        ADDR:     if (scl_rise && bit_cnt == 4'd7) state_nxt = addr_match ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall && bit_cnt == 4'd9) state_nxt = sr[0] ? RDATA : PTR;
        PTR:      if (scl_fall && bit_cnt == 4'd9) state_nxt = WDATA;
        RDATA:    if (scl_rise && bit_cnt == 4'd8 && sda_s) state_nxt = WAIT_STOP;
        default:  state_nxt = state;
      endcase
    end
  end

  // bit_cnt counts scl rises in the 9-bit frame; 8 = byte done, 9 = ACK sampled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr         <= '0;
      bit_cnt    <= '0;
      ptr        <= '0;
      own_addr_q <= '0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (stop_det || start_det) begin
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
        if (start_det) own_addr_q <= own_addr;
      end else begin
        case (state)
          ADDR, ADDR_ACK, PTR, WDATA: begin
            if (scl_rise) begin
              if (bit_cnt < 4'd8) sr <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7 && state == PTR) ptr <= rx_byte[PW-1:0];
              if (bit_cnt == 4'd7 && state == WDATA) begin
                regs[ptr] <= rx_byte;
                wr_valid  <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
                ptr       <= ptr + 1'b1;
              end
            end
            if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
              if (state == ADDR_ACK) busy <= 1'b1;
            end
            if (scl_fall && bit_cnt == 4'd9) begin
              bit_cnt <= '0;
              if (state == ADDR_ACK && sr[0]) begin
                sr     <= regs[ptr];
                sda_oe <= ~regs[ptr][7];
              end else begin
                sda_oe <= 1'b0;
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              if (bit_cnt == 4'd8) begin
                ptr <= ptr + 1'b1;
                if (!sda_s) bit_cnt <= 4'd9;
                else        busy    <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
              end else if (bit_cnt == 4'd9) begin
                sr      <= regs[ptr];
                sda_oe  <= ~regs[ptr][7];
                bit_cnt <= '0;
              end else if (bit_cnt != 4'd0) begin
                sr     <= {sr[6:0], 1'b0};
                sda_oe <= ~sr[6];
              end
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) reg_rd_data <= '0;
    else      reg_rd_data <= regs[reg_rd_addr];
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master plus a register/pointer
// reference model; directed scenarios followed by randomized transactions.
module tb_i2c_reg_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_pull = 1'b0;
  logic [6:0] own_addr = 7'h51;
  logic [3:0] reg_rd_addr = 4'd0;
  wire  [7:0] reg_rd_data;
  wire        wr_valid;
  wire  [3:0] wr_addr;
  wire  [7:0] wr_data;
  wire        busy;
  wire        sda;

  assign sda = m_pull ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_reg_slave #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .own_addr(own_addr), .scl(scl), .sda(sda),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  mregs [16];
  int          mptr = 0;
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  logic [7:0]  buf_q[$];

  always @(negedge clk) if (rst && wr_valid) got_q.push_back({wr_addr, wr_data});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic q();
    repeat (5) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_pull = 1'b0; q(); scl = 1'b1; q(); m_pull = 1'b1; q(); scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_pull = 1'b1; q(); scl = 1'b1; q(); m_pull = 1'b0; q(); q();
  endtask

  task automatic write_bit(input logic b);
    m_pull = ~b; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
  endtask

  task automatic read_bit(output logic b);
    m_pull = 1'b0; q(); scl = 1'b1; q(); b = sda; q(); scl = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(x);
    ack = ~x;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic mack);
    logic x;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(x);
      b = {b[6:0], x};
    end
    write_bit(~mack);
  endtask

  task automatic check_reg(input int idx);
    reg_rd_addr = idx[3:0];
    @(posedge clk); @(posedge clk); @(negedge clk);
    check($sformatf("reg[%0d]", idx), reg_rd_data, mregs[idx]);
  endtask

  task automatic check_wr();
    int n;
    check("wr_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("wr_entry", got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // pointer byte then the bytes in buf_q, ended by STOP
  task automatic write_txn(input logic [7:0] pb);
    logic a;
    i2c_start();
    send_byte(8'hA2, a); check("addr_ack", a, 1'b1);
    check("busy_wr", busy, 1'b1);
    send_byte(pb, a);    check("ptr_ack", a, 1'b1);
    mptr = pb % 16;
    foreach (buf_q[i]) begin
      send_byte(buf_q[i], a); check("data_ack", a, 1'b1);
      mregs[mptr] = buf_q[i];
      exp_q.push_back({mptr[3:0], buf_q[i]});
      mptr = (mptr + 1) % 16;
    end
    i2c_stop();
    q();
    check("busy_after_stop", busy, 1'b0);
    check_wr();
  endtask

  task automatic read_txn(input int n, input logic set_ptr, input logic [7:0] pb);
    logic a;
    logic [7:0] b;
    i2c_start();
    if (set_ptr) begin
      send_byte(8'hA2, a); check("addr_ack", a, 1'b1);
      send_byte(pb, a);    check("ptr_ack", a, 1'b1);
      mptr = pb % 16;
      i2c_start();
    end
    send_byte(8'hA3, a); check("rd_addr_ack", a, 1'b1);
    check("busy_rd", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      recv_byte(b, i != n - 1);
      check("rd_data", b, mregs[mptr]);
      mptr = (mptr + 1) % 16;
    end
    check("sda_released_after_nack", sda, 1'b1);
    i2c_stop();
    q();
    check("busy_after_rd", busy, 1'b0);
  endtask

  initial begin
    logic       a;
    logic       x;
    logic [7:0] pb;
    int         len;

    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_rd_data", reg_rd_data, 8'h00);
    check("rst_sda", sda, 1'b1);
    rst = 1'b1;
    q();

    // basic write of two bytes at pointer 3
    buf_q = '{8'h3C, 8'h5A};
    write_txn(8'h03);
    check_reg(3);
    check_reg(4);

    // pointer write, repeated START, read two bytes
    read_txn(2, 1'b1, 8'h03);
    // read without pointer write continues at ptr=5
    read_txn(1, 1'b0, 8'h00);

    // wrong address and general call: no ACK, nothing changes
    i2c_start();
    send_byte(8'hA0, a); check("wrong_addr_nack", a, 1'b0);
    send_byte(8'h55, a); check("wrong_addr_data_nack", a, 1'b0);
    check("wrong_addr_busy", busy, 1'b0);
    i2c_stop();
    i2c_start();
    send_byte(8'h00, a); check("gen_call_nack", a, 1'b0);
    i2c_stop();
    q();
    check_wr();
    for (int i = 0; i < 16; i++) check_reg(i);

    // wrap of the pointer past DEPTH-1, pointer modulo DEPTH
    buf_q = '{8'h11, 8'h22};
    write_txn(8'h0F);
    check_reg(15);
    check_reg(0);
    buf_q.delete();
    write_txn(8'h13);
    read_txn(1, 1'b0, 8'h00);

    // partial byte cut off by STOP is discarded
    i2c_start();
    send_byte(8'hA2, a); check("addr_ack", a, 1'b1);
    send_byte(8'h07, a); check("ptr_ack", a, 1'b1);
    mptr = 7;
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    q();
    check("partial_busy", busy, 1'b0);
    check_wr();
    check_reg(7);
    read_txn(1, 1'b0, 8'h00);

    // randomized write/read-back
    for (int t = 0; t < 6; t++) begin
      pb  = 8'($urandom_range(0, 255));
      len = $urandom_range(1, 4);
      buf_q.delete();
      for (int i = 0; i < len; i++) buf_q.push_back(8'($urandom));
      write_txn(pb);
      read_txn(len, 1'b1, pb);
      check_reg($urandom_range(0, 15));
    end

    // reset in the middle of a read byte whose leading bits are 0
    buf_q = '{8'h12};
    write_txn(8'h02);
    i2c_start();
    send_byte(8'hA2, a); check("addr_ack", a, 1'b1);
    send_byte(8'h02, a); check("ptr_ack", a, 1'b1);
    i2c_start();
    send_byte(8'hA3, a); check("rd_addr_ack", a, 1'b1);
    check("rd_msb_driven", sda, 1'b0);
    read_bit(x); read_bit(x);
    check("rd_bit5_driven", sda, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_sda", sda, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_wr_valid", wr_valid, 1'b0);
    check("mid_rst_wr_addr", wr_addr, 4'd0);
    check("mid_rst_wr_data", wr_data, 8'h00);
    check("mid_rst_rd_data", reg_rd_data, 8'h00);
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 0;
    got_q.delete();
    m_pull = 1'b0;
    scl = 1'b1;
    q();
    rst = 1'b1;
    q();
    check_reg(2);
    read_txn(1, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
